// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and helpers for the ioctl-to-SDRAM download path.
//   prog_st_t    : write-sequencer states
//   prog_entry_t : one queued SDRAM byte write {bank, word address, byte, active-low mask}
//   bank_of()    : bank number of a byte address, given the three bank start addresses
package jtframe_dwnld_pkg;

  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned PROG_AW = 22;
  localparam int unsigned OFF_W   = PROG_AW + 1;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 2 * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } prog_st_t;

  typedef struct packed {
    logic [1:0]         ba;
    logic [PROG_AW-1:0] addr;
    logic [BYTE_W-1:0]  data;
    logic [1:0]         mask;
  } prog_entry_t;

  function automatic logic [1:0] bank_of(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] ba1_start,
                                         input logic [ADDR_W-1:0] ba2_start,
                                         input logic [ADDR_W-1:0] ba3_start);
    if (addr >= ba3_start)      return 2'd3;
    else if (addr >= ba2_start) return 2'd2;
    else if (addr >= ba1_start) return 2'd1;
    else                        return 2'd0;
  endfunction

endpackage

// File: rtl/jtframe_prog_packer_if.sv
// Bus bundle between the ioctl source / SDRAM sink and the packer.
//   master : the packer (consumes ioctl_* and prog_rdy, drives prog_*, prom_*, status)
//   slave  : the environment (drives ioctl_* and prog_rdy)
interface jtframe_prog_packer_if;
  import jtframe_dwnld_pkg::*;

  logic                 downloading;
  logic [ADDR_W-1:0]    ioctl_addr;
  logic [BYTE_W-1:0]    ioctl_data;
  logic                 ioctl_wr;
  logic [PROG_AW-1:0]   prog_addr;
  logic [WORD_W-1:0]    prog_data;
  logic [1:0]           prog_mask;
  logic [1:0]           prog_ba;
  logic                 prog_we;
  logic                 prog_rdy;
  logic                 prom_we;
  logic [ADDR_W-1:0]    prom_addr;
  logic [BYTE_W-1:0]    prom_data;
  logic                 dwnld_busy;
  logic                 overflow;

  modport master (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
    output prom_we, prom_addr, prom_data, dwnld_busy, overflow
  );

  modport slave (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
    input  prom_we, prom_addr, prom_data, dwnld_busy, overflow
  );

endinterface

// File: rtl/jtframe_fifo_sync.sv
// Single-clock FIFO, 2**AW entries of type T, head visible without a pop.
//   clk, rst_n        : clock, async active-low reset (pointers only)
//   push_i, data_i    : write one entry (caller must not push a full FIFO unless popping)
//   pop_i             : drop the head entry (caller must not pop an empty FIFO)
//   head_c_o          : current head entry
//   full_c_o/empty_c_o: status decoded from the pointers
module jtframe_fifo_sync #(
  parameter type         T  = logic [7:0],
  parameter int unsigned AW = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_c_o,
  output logic full_c_o,
  output logic empty_c_o
);

  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  T            mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
    end
  end

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty_c_o = (wr_q == rd_q);
  assign full_c_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_c_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/jtframe_prog_packer.sv
// ioctl byte stream -> SDRAM prog_* word writes with bank select, byte masks and
// prog_rdy handshake; bytes at/above PROM_START go out as a prom_we strobe instead.
//   clk, rst_n : clock, async active-low reset
//   bus        : ioctl inputs, prog_* / prom_* outputs, dwnld_busy, overflow
module jtframe_prog_packer
  import jtframe_dwnld_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BA1_START  = 25'h10_0000,
  parameter logic [ADDR_W-1:0] BA2_START  = 25'h20_0000,
  parameter logic [ADDR_W-1:0] BA3_START  = 25'h30_0000,
  parameter logic [ADDR_W-1:0] PROM_START = 25'h40_0000,
  parameter int unsigned       FIFO_AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtframe_prog_packer_if.master bus
);

  prog_st_t            state_q, state_d;
  logic [PROG_AW-1:0]  prog_addr_q, prog_addr_d;
  logic [WORD_W-1:0]   prog_data_q, prog_data_d;
  logic [1:0]          prog_mask_q, prog_mask_d;
  logic [1:0]          prog_ba_q, prog_ba_d;
  logic                prog_we_q, prog_we_d;
  logic                prom_we_q, prom_we_d;
  logic [ADDR_W-1:0]   prom_addr_q, prom_addr_d;
  logic [BYTE_W-1:0]   prom_data_q, prom_data_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                dl_q;

  logic [1:0]          ba_c;
  logic [ADDR_W-1:0]   bank_base_c;
  logic [OFF_W-1:0]    offset_c;
  logic                is_prom_c, want_push_c, push_c, pop_c;
  prog_entry_t         push_entry_c, head_c;
  logic                fifo_full_c, fifo_empty_c;

  // Address decode of the incoming byte.
  always_comb begin
    ba_c = bank_of(bus.ioctl_addr, BA1_START, BA2_START, BA3_START);
    case (ba_c)
      2'd1:    bank_base_c = BA1_START;
      2'd2:    bank_base_c = BA2_START;
      2'd3:    bank_base_c = BA3_START;
      default: bank_base_c = '0;
    endcase
    offset_c          = OFF_W'(bus.ioctl_addr - bank_base_c);
    is_prom_c         = (bus.ioctl_addr >= PROM_START);
    want_push_c       = bus.ioctl_wr & bus.downloading & ~is_prom_c;
    push_entry_c.ba   = ba_c;
    push_entry_c.addr = offset_c[OFF_W-1:1];
    push_entry_c.data = bus.ioctl_data;
    push_entry_c.mask = offset_c[0] ? 2'b01 : 2'b10;
  end

  jtframe_fifo_sync #(
    .T  (prog_entry_t),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_c),
    .data_i    (push_entry_c),
    .pop_i     (pop_c),
    .head_c_o  (head_c),
    .full_c_o  (fifo_full_c),
    .empty_c_o (fifo_empty_c)
  );

  // Write sequencer plus push, PROM, busy and overflow next-state.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_ba_d   = prog_ba_q;
    prog_we_d   = prog_we_q;
    pop_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          state_d     = WRITE;
          prog_we_d   = 1'b1;
          prog_addr_d = head_c.addr;
          prog_data_d = {head_c.data, head_c.data};
          prog_mask_d = head_c.mask;
          prog_ba_d   = head_c.ba;
        end
      end
      WRITE: begin
        if (bus.prog_rdy) begin
          pop_c     = 1'b1;
          prog_we_d = 1'b0;
          state_d   = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_c = want_push_c & (~fifo_full_c | pop_c);

    overflow_d = overflow_q;
    if (bus.downloading & ~dl_q)                  overflow_d = 1'b0;
    if (want_push_c & fifo_full_c & ~pop_c)       overflow_d = 1'b1;

    prom_we_d   = bus.ioctl_wr & bus.downloading & is_prom_c;
    prom_addr_d = prom_we_d ? (bus.ioctl_addr - PROM_START) : prom_addr_q;
    prom_data_d = prom_we_d ? bus.ioctl_data : prom_data_q;

    busy_d = bus.downloading | ~fifo_empty_c | prog_we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
      prog_ba_q   <= '0;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_ba_q   <= prog_ba_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      dl_q        <= bus.downloading;
    end
  end

  assign bus.prog_addr  = prog_addr_q;
  assign bus.prog_data  = prog_data_q;
  assign bus.prog_mask  = prog_mask_q;
  assign bus.prog_ba    = prog_ba_q;
  assign bus.prog_we    = prog_we_q;
  assign bus.prom_we    = prom_we_q;
  assign bus.prom_addr  = prom_addr_q;
  assign bus.prom_data  = prom_data_q;
  assign bus.dwnld_busy = busy_q;
  assign bus.overflow   = overflow_q;

endmodule
